// File: rtl/cache_def_pkg.sv
// Shared constants, bus types and controller state type for the direct-mapped cache.
// Line geometry: 1024 lines x 128 bit, 32-bit CPU words, 32-bit byte addresses.
package cache_def_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INDEX_W = 10;
    localparam int unsigned OFFS_W  = 4;
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFS_W;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LINE_W  = 128;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_type;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } cpu_req_type;

    typedef struct packed {
        logic              valid;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        cache_data_type    data;
    } mem_req_type;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } ctrl_state_e;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFS_W{1'b0}}};
    endfunction

    // {w, 5'b0} is the bit offset of word w inside the 128-bit line.
    function automatic logic [WORD_W-1:0] get_word(input cache_data_type line,
                                                   input logic [1:0]     w);
        return line[{w, 5'b0} +: WORD_W];
    endfunction

    function automatic cache_data_type put_word(input cache_data_type    line,
                                                input logic [1:0]        w,
                                                input logic [WORD_W-1:0] data);
        cache_data_type l;
        l = line;
        l[{w, 5'b0} +: WORD_W] = data;
        return l;
    endfunction

endpackage

// File: rtl/dm_cache_stats.sv
// Saturating hit / miss / write-back counters for dm_cache_ctrl (built only with CACHE_STATS_EN).
// The compare that follows a refill is a re-check of an already-counted miss, so it is skipped.
module dm_cache_stats
    import cache_def_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmp_i,
    input  logic        hit_i,
    input  logic        victim_dirty_i,
    input  logic        refill_i,
    output logic [31:0] hits_o,
    output logic [31:0] misses_o,
    output logic [31:0] wbacks_o
);

    logic [31:0] hits_q, misses_q, wbacks_q;
    logic        recheck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q    <= '0;
            misses_q  <= '0;
            wbacks_q  <= '0;
            recheck_q <= 1'b0;
        end else begin
            if (refill_i) begin
                recheck_q <= 1'b1;
            end else if (cmp_i) begin
                recheck_q <= 1'b0;
            end
            if (cmp_i && hit_i && !recheck_q && (hits_q != '1)) begin
                hits_q <= hits_q + 32'd1;
            end
            if (cmp_i && !hit_i && (misses_q != '1)) begin
                misses_q <= misses_q + 32'd1;
            end
            if (cmp_i && !hit_i && victim_dirty_i && (wbacks_q != '1)) begin
                wbacks_q <= wbacks_q + 32'd1;
            end
        end
    end

    assign hits_o   = hits_q;
    assign misses_o = misses_q;
    assign wbacks_o = wbacks_q;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Blocking controller for a 1024 x 128-bit direct-mapped, write-back, write-allocate cache.
// Define CACHE_STATS_EN to add stat_hits / stat_misses / stat_wbacks counter ports.
module dm_cache_ctrl
    import cache_def_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_rw,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [WORD_W-1:0]   cpu_req_data,
    output logic                cpu_res_valid,
    output logic [WORD_W-1:0]   cpu_res_data,
    output cache_req_type       tag_req,
    output cache_tag_type       tag_write,
    input  cache_tag_type       tag_read,
    output cache_req_type       data_req,
    output cache_data_type      data_write,
    input  cache_data_type      data_read,
    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output cache_data_type      mem_req_data,
    input  logic                mem_data_ready,
    input  cache_data_type      mem_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
    output logic [31:0]         stat_wbacks
`endif
);

    ctrl_state_e        state_q, state_d;
    cpu_req_type        req_q, req_d;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic               hit;
    logic               victim_dirty;
    mem_req_type        mem_c;
    logic               unused_addr_bits;

    assign req_tag          = req_q.addr[ADDR_W-1 -: TAG_W];
    assign req_index        = req_q.addr[OFFS_W +: INDEX_W];
    assign req_word         = req_q.addr[OFFS_W-1:2];
    assign unused_addr_bits = ^req_q.addr[1:0];

    assign hit          = tag_read.valid && (tag_read.tag == req_tag);
    assign victim_dirty = tag_read.valid && tag_read.dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Both arrays are always addressed by the held request, so a refill lands on the
    // line that the following compare reads back.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        cpu_req_ready  = 1'b0;
        cpu_res_valid  = 1'b0;
        cpu_res_data   = '0;
        tag_req        = '0;
        tag_req.index  = req_index;
        tag_write      = '0;
        data_req       = '0;
        data_req.index = req_index;
        data_write     = '0;
        mem_c          = '0;

        case (state_q)
            IDLE: begin
                cpu_req_ready = rst_n;
                if (cpu_req_valid) begin
                    req_d   = '{rw: cpu_req_rw, addr: cpu_req_addr, data: cpu_req_data};
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (hit) begin
                    cpu_res_valid = 1'b1;
                    if (req_q.rw) begin
                        data_write   = put_word(data_read, req_word, req_q.data);
                        data_req.we  = 1'b1;
                        tag_write    = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                        tag_req.we   = 1'b1;
                    end else begin
                        cpu_res_data = get_word(data_read, req_word);
                    end
                    state_d = IDLE;
                end else if (victim_dirty) begin
                    state_d = WRITE_BACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end

            WRITE_BACK: begin
                mem_c = '{valid: 1'b1, rw: 1'b1,
                          addr: line_addr(tag_read.tag, req_index), data: data_read};
                if (mem_data_ready) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                mem_c = '{valid: 1'b1, rw: 1'b0,
                          addr: line_addr(req_tag, req_index), data: '0};
                if (mem_data_ready) begin
                    data_write  = mem_data;
                    data_req.we = 1'b1;
                    tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
                    tag_req.we  = 1'b1;
                    state_d     = COMPARE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign mem_req_valid = mem_c.valid;
    assign mem_req_rw    = mem_c.rw;
    assign mem_req_addr  = mem_c.addr;
    assign mem_req_data  = mem_c.data;

`ifdef CACHE_STATS_EN
    dm_cache_stats u_stats (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmp_i          (state_q == COMPARE),
        .hit_i          (hit),
        .victim_dirty_i (victim_dirty),
        .refill_i       ((state_q == ALLOCATE) && mem_data_ready),
        .hits_o         (stat_hits),
        .misses_o       (stat_misses),
        .wbacks_o       (stat_wbacks)
    );
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: tag/data stores and a latency-programmable memory
// around the DUT, checked against a flat word-memory reference plus a per-line cache view.
module tb_dm_cache_ctrl;
    import cache_def_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cpu_req_valid, cpu_req_ready, cpu_req_rw;
    logic [31:0]    cpu_req_addr, cpu_req_data;
    logic           cpu_res_valid;
    logic [31:0]    cpu_res_data;
    cache_req_type  tag_req, data_req;
    cache_tag_type  tag_write, tag_read;
    cache_data_type data_write, data_read, mem_req_data, mem_data;
    logic           mem_req_valid, mem_req_rw, mem_data_ready;
    logic [31:0]    mem_req_addr;
`ifdef CACHE_STATS_EN
    logic [31:0]    stat_hits, stat_misses, stat_wbacks;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_res_valid(cpu_res_valid), .cpu_res_data(cpu_res_data),
        .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read),
        .data_req(data_req), .data_write(data_write), .data_read(data_read),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_data_ready(mem_data_ready), .mem_data(mem_data)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
`endif
    );

    // Tag and data stores: combinational read, write on posedge.
    cache_tag_type  tag_mem  [1024] = '{default: '0};
    cache_data_type data_mem [1024] = '{default: '0};
    assign tag_read  = tag_mem[tag_req.index];
    assign data_read = data_mem[data_req.index];
    always @(posedge clk) begin
        if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
        if (data_req.we) data_mem[data_req.index] <= data_write;
    end

    function automatic logic [31:0] pat_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endfunction

    // Next-level memory: lines never written back hold pat_word of each word address.
    typedef struct { logic rw; logic [31:0] addr; cache_data_type data; } mem_op_t;
    mem_op_t        mem_log [$];
    cache_data_type main_mem [logic [31:0]];
    int unsigned    mem_lat = 0;

    function automatic cache_data_type mem_line(input logic [31:0] a);
        cache_data_type l;
        if (main_mem.exists(a)) return main_mem[a];
        for (int w = 0; w < 4; w++) l[32*w +: 32] = pat_word(a + 32'(4*w));
        return l;
    endfunction

    initial begin : mem_model
        bit          busy;
        int unsigned wait_cnt;
        busy = 0;
        wait_cnt = 0;
        mem_data_ready = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_data_ready = 1'b0;
            if (!rst_n || !mem_req_valid) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    wait_cnt = mem_lat;
                end
                if (wait_cnt == 0) begin
                    busy = 0;
                    mem_data_ready = 1'b1;
                    if (mem_req_rw) main_mem[mem_req_addr] = mem_req_data;
                    else            mem_data = mem_line(mem_req_addr);
                    mem_log.push_back('{mem_req_rw, mem_req_addr, mem_req_rw ? mem_req_data : mem_data});
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Reference: architectural word memory plus the cache's per-line residency.
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_valid [1024];
    bit          m_dirty [1024];
    logic [17:0] m_tag   [1024];

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return ref_mem.exists(wa) ? ref_mem[wa] : pat_word(wa);
    endfunction

    task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input int unsigned lat, input bit hold_junk, input string name);
        logic [9:0]     idx;
        logic [17:0]    tg;
        bit             hit, prev_wait;
        int unsigned    exp_lat, n_lat, cyc;
        int             base;
        mem_op_t        exp_ops [$];
        mem_op_t        op;
        logic [31:0]    exp_rd, wba, prev_addr;
        logic           prev_rw;
        cache_data_type wline, prev_data;

        idx = addr[13:4];
        tg  = addr[31:14];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_rd = ref_get(addr);
        if (hit) begin
            exp_lat = 1;
        end else begin
            if (m_valid[idx] && m_dirty[idx]) begin
                wba = {m_tag[idx], idx, 4'b0000};
                for (int w = 0; w < 4; w++) wline[32*w +: 32] = ref_get(wba + 32'(4*w));
                exp_ops.push_back('{1'b1, wba, wline});
                exp_lat = 2 * (lat + 1) + 2;
            end else begin
                exp_lat = lat + 3;
            end
            exp_ops.push_back('{1'b0, {tg, idx, 4'b0000}, '0});
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 0;
        end
        if (rw) begin
            m_dirty[idx] = 1;
            ref_mem[{addr[31:2], 2'b00}] = wdata;
        end

        mem_lat = lat;
        base = mem_log.size();
        cyc = 0;
        @(negedge clk); #1;
        while (!cpu_req_ready && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin
            $display("FAIL %s ready-timeout: cpu_req_ready=%b required 1", name, cpu_req_ready);
            return;
        end
        n_pass++;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_data  = wdata;
        @(negedge clk); #1;
        if (hold_junk) begin
            cpu_req_rw   = 1'b1;
            cpu_req_addr = addr ^ 32'h0008_0000;
            cpu_req_data = ~wdata;
        end else begin
            cpu_req_valid = 1'b0;
        end

        n_lat = 1;
        prev_wait = 0;
        while (!cpu_res_valid && n_lat < 200) begin
            n_checks++;
            if (cpu_req_ready !== 1'b0)
                $display("FAIL %s busy-ready: cpu_req_ready=%b required 0", name, cpu_req_ready);
            else n_pass++;
            if (mem_req_valid && !mem_data_ready) begin
                n_checks++;
                if (tag_req.we || data_req.we ||
                    (prev_wait && ({prev_rw, prev_addr, prev_data} !== {mem_req_rw, mem_req_addr, mem_req_data})))
                    $display("FAIL %s stall-stable: we=%b/%b rw=%b addr=%h required no we, rw=%b addr=%h",
                             name, tag_req.we, data_req.we, mem_req_rw, mem_req_addr, prev_rw, prev_addr);
                else n_pass++;
                prev_wait = 1;
                prev_rw   = mem_req_rw;
                prev_addr = mem_req_addr;
                prev_data = mem_req_data;
            end else begin
                prev_wait = 0;
            end
            @(negedge clk); #1;
            n_lat++;
        end
        cpu_req_valid = 1'b0;

        n_checks++;
        if (cpu_res_valid !== 1'b1) $display("FAIL %s response-timeout: cpu_res_valid=%b required 1", name, cpu_res_valid);
        else n_pass++;
        n_checks++;
        if (n_lat != exp_lat) $display("FAIL %s latency: got %0d required %0d", name, n_lat, exp_lat);
        else n_pass++;
        if (!rw) begin
            n_checks++;
            if (cpu_res_data !== exp_rd) $display("FAIL %s read-data: got %h required %h", name, cpu_res_data, exp_rd);
            else n_pass++;
        end
        n_checks++;
        if (mem_log.size() - base != exp_ops.size()) begin
            $display("FAIL %s mem-op-count: got %0d required %0d", name, mem_log.size() - base, exp_ops.size());
        end else begin
            n_pass++;
            foreach (exp_ops[i]) begin
                op = mem_log[base + i];
                n_checks++;
                if (op.rw !== exp_ops[i].rw || op.addr !== exp_ops[i].addr ||
                    (exp_ops[i].rw && op.data !== exp_ops[i].data))
                    $display("FAIL %s mem-op%0d: got rw=%b addr=%h data=%h required rw=%b addr=%h data=%h",
                             name, i, op.rw, op.addr, op.data, exp_ops[i].rw, exp_ops[i].addr, exp_ops[i].data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_rw = 1'b0;
        cpu_req_addr = '0;
        cpu_req_data = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({cpu_req_ready, cpu_res_valid, mem_req_valid, mem_req_rw, tag_req.we, data_req.we} !== 6'b0)
            $display("FAIL reset-ctrl: ready/res/mem/rw/twe/dwe=%b required 000000",
                     {cpu_req_ready, cpu_res_valid, mem_req_valid, mem_req_rw, tag_req.we, data_req.we});
        else n_pass++;
        n_checks++;
        if (mem_req_addr !== 32'h0 || cpu_res_data !== 32'h0 || tag_req.index !== 10'h0)
            $display("FAIL reset-data: mem_addr=%h res_data=%h index=%h required 0", mem_req_addr, cpu_res_data, tag_req.index);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (cpu_req_ready !== 1'b1) $display("FAIL reset-idle-ready: got %b required 1", cpu_req_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        cache_tag_type  t;
        cache_data_type l;
        do_access(1'b0, 32'h0000_0040, 32'h0, 2, 0, "cold-read");
        do_access(1'b0, 32'h0000_0040, 32'h0, 0, 0, "reread-hit");
        do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 0, "write-hit");
        do_access(1'b0, 32'h0000_0044, 32'h0, 0, 0, "read-after-write");
        t = tag_mem[4];
        l = data_mem[4];
        n_checks++;
        if (t !== '{valid: 1'b1, dirty: 1'b1, tag: 18'h0}) $display("FAIL dirty-tag: got %h required %h", t, {2'b11, 18'h0});
        else n_pass++;
        n_checks++;
        if (l[31:0] !== pat_word(32'h40) || l[63:32] !== 32'hDEAD_BEEF ||
            l[95:64] !== pat_word(32'h48) || l[127:96] !== pat_word(32'h4C))
            $display("FAIL line-merge: got %h required %h_%h_%h_%h", l, pat_word(32'h4C), pat_word(32'h48), 32'hDEAD_BEEF, pat_word(32'h40));
        else n_pass++;
        do_access(1'b0, 32'h0001_0044, 32'h0, 1, 0, "dirty-evict");
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        n_checks++;
        if (stat_hits !== 32'd3 || stat_misses !== 32'd2 || stat_wbacks !== 32'd1)
            $display("FAIL stats: hits=%0d misses=%0d wbacks=%0d required 3 2 1", stat_hits, stat_misses, stat_wbacks);
        else n_pass++;
    endtask
`endif

    task automatic test_index_wrap();
        do_access(1'b1, 32'h0000_3FF4, 32'h1111_2222, 0, 0, "wrap-w1023");
        do_access(1'b1, 32'h0000_4004, 32'h3333_4444, 0, 0, "wrap-w0");
        do_access(1'b0, 32'h0000_3FF4, 32'h0, 0, 0, "wrap-r1023");
        do_access(1'b0, 32'h0000_4004, 32'h0, 0, 0, "wrap-r0");
    endtask

    task automatic test_stall();
        do_access(1'b1, 32'h0000_0080, $urandom, 0, 0, "stall-prep");
        do_access(1'b0, 32'h0002_0080, 32'h0, 20, 1, "stall-dirty");
    endtask

    task automatic test_reset_mid();
        cache_tag_type  t0;
        cache_data_type d0;
        int             base, cyc;
        mem_lat = 10;
        base = mem_log.size();
        @(negedge clk); #1;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h0000_0300;
        @(negedge clk); #1;
        cpu_req_valid = 1'b0;
        cyc = 0;
        while (!(mem_req_valid && !mem_req_rw) && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (!(mem_req_valid && !mem_req_rw)) $display("FAIL midrst-alloc-timeout: mem_req_valid=%b required 1", mem_req_valid);
        else n_pass++;
        repeat (3) @(negedge clk);
        t0 = tag_mem[10'h30];
        d0 = data_mem[10'h30];
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_req_ready, cpu_res_valid, mem_req_valid, tag_req.we, data_req.we} !== 5'b0)
            $display("FAIL midrst-outputs: ready/res/mem/twe/dwe=%b required 00000",
                     {cpu_req_ready, cpu_res_valid, mem_req_valid, tag_req.we, data_req.we});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tag_mem[10'h30] !== t0 || data_mem[10'h30] !== d0 || mem_log.size() != base)
            $display("FAIL midrst-no-write: tag=%h data=%h ops=%0d required tag=%h data=%h ops=%0d",
                     tag_mem[10'h30], data_mem[10'h30], mem_log.size(), t0, d0, base);
        else n_pass++;
        do_access(1'b0, 32'h0000_0300, 32'h0, 1, 0, "post-reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_access(i[0], 32'h0000_3FF0 + 32'(4 * (i % 4)), $urandom, 0, 1, "b2b");
    endtask

    task automatic test_random();
        logic [9:0]  idx_set [4] = '{10'd0, 10'd1, 10'd4, 10'd1023};
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = {18'($urandom_range(3, 0)), idx_set[$urandom_range(3, 0)], 2'($urandom_range(3, 0)), 2'b00};
            do_access(1'($urandom_range(1, 0)), a, $urandom, $urandom_range(3, 0),
                      1'($urandom_range(1, 0)), "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_index_wrap();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
